// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - iterative RV32M multiply/divide unit for the Execute stage
//
// Ports:
//   clk_i     clock
//   resetn_i  synchronous active-low reset
//   start_i   valid M-op in Execute (held high while the instruction stalls)
//   funct3_i  RV32M op select (MUL..REMU)
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   flush_i   Execute flush, aborts the current operation
//   busy_o    stall request to pipeline control
//   valid_o   result_o holds a retiring result this cycle
//   result_o  operation result
//
// Build option: define MULDIV_FAST_MUL_EN to compute MUL/MULH/MULHSU/MULHU
// combinationally in the start cycle; division stays iterative.
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          f3_q;
    logic [XLEN-1:0]     opa_q;      // multiplicand magnitude
    logic [XLEN-1:0]     opb_q;      // divisor magnitude
    logic                neg_q;      // negate final result
    logic [2*XLEN-1:0]   prod_q;     // {partial product, remaining multiplier bits}
    logic [XLEN:0]       rem_q;      // partial remainder
    logic [XLEN-1:0]     quo_q;      // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0]     result_q;

    // ---------------------------------------------------------------
    // Operand decode in IDLE
    // ---------------------------------------------------------------
    logic            sgn_a, sgn_b;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            is_div;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] quick_res;
    logic            mul_bypass;
    logic            start_ok;
    logic            start_neg;

    assign sgn_a = (funct3_i == 3'd1) | (funct3_i == 3'd2) |
                   (funct3_i == 3'd4) | (funct3_i == 3'd6);
    assign sgn_b = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);

    assign a_neg   = sgn_a & rs1_i[XLEN-1];
    assign b_neg   = sgn_b & rs2_i[XLEN-1];
    assign rs1_mag = a_neg ? (~rs1_i + 1'b1) : rs1_i;
    assign rs2_mag = b_neg ? (~rs2_i + 1'b1) : rs2_i;

    // Remainder takes the dividend's sign; everything else the XOR of both.
    assign start_neg = (funct3_i[2] & funct3_i[1]) ? a_neg : (a_neg ^ b_neg);

    assign is_div   = funct3_i[2];
    assign div_zero = (rs2_i == '0);
    assign div_ovf  = ~funct3_i[0] &
                      (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                      (rs2_i == {XLEN{1'b1}});

    // funct3[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        quick_res = '0;
        if (div_zero)
            quick_res = funct3_i[1] ? rs1_i : {XLEN{1'b1}};
        else
            quick_res = funct3_i[1] ? '0 : rs1_i;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fm_a, fm_b;
    logic signed [2*XLEN-1:0] fm_p;
    logic [XLEN-1:0]          fast_res;
    logic                     fast_hit;

    assign mul_bypass = ~funct3_i[2];
    assign fm_a       = {sgn_a & rs1_i[XLEN-1], rs1_i};
    assign fm_b       = {sgn_b & rs2_i[XLEN-1], rs2_i};
    assign fm_p       = fm_a * fm_b;
    assign fast_res   = (funct3_i == 3'd0) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
    assign fast_hit   = (state == IDLE) & start_i & ~flush_i & mul_bypass;
`else
    assign mul_bypass = 1'b0;
`endif

    assign start_ok = start_i & ~flush_i & ~mul_bypass;

    // ---------------------------------------------------------------
    // Iteration step
    // ---------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt;
    logic [XLEN:0]     rem_shift;
    logic [XLEN+1:0]   rem_diff;
    logic              rem_ok;
    logic [XLEN:0]     rem_nxt;
    logic [XLEN-1:0]   quo_nxt;

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                      (prod_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
    assign prod_nxt = {mul_sum, prod_q[XLEN-1:1]};

    // Restoring division: keep the trial subtraction only if it did not borrow.
    assign rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign rem_diff  = {1'b0, rem_shift} - {2'b00, opb_q};
    assign rem_ok    = ~rem_diff[XLEN+1];
    assign rem_nxt   = rem_ok ? rem_diff[XLEN:0] : rem_shift;
    assign quo_nxt   = {quo_q[XLEN-2:0], rem_ok};

    // Final result, formed from the last iteration's values.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   calc_res;

    assign prod_fix = neg_q ? (~prod_nxt + 1'b1) : prod_nxt;
    assign quo_fix  = neg_q ? (~quo_nxt + 1'b1) : quo_nxt;
    assign rem_fix  = neg_q ? (~rem_nxt[XLEN-1:0] + 1'b1) : rem_nxt[XLEN-1:0];

    always_comb begin
        calc_res = '0;
        case (f3_q)
            3'd0:                calc_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    calc_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:          calc_res = quo_fix;
            default:             calc_res = rem_fix;
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state    <= IDLE;
            cnt      <= '0;
            f3_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        f3_q   <= funct3_i;
                        opa_q  <= rs1_mag;
                        opb_q  <= rs2_mag;
                        neg_q  <= start_neg;
                        prod_q <= {{XLEN{1'b0}}, rs2_mag};
                        rem_q  <= '0;
                        quo_q  <= rs1_mag;
                        cnt    <= '0;
                        if (is_div && (div_zero || div_ovf)) begin
                            result_q <= quick_res;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (f3_q[2]) begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                    end else begin
                        prod_q <= prod_nxt;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        result_q <= calc_res;
                        state    <= DONE;
                    end
                end
                // start_i seen here belongs to the instruction now retiring.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign busy_o = (state == IDLE) ? start_ok : (state == CALC);

`ifdef MULDIV_FAST_MUL_EN
    assign valid_o  = ((state == DONE) & ~flush_i) | fast_hit;
    assign result_o = fast_hit ? fast_res : result_q;
`else
    assign valid_o  = (state == DONE) & ~flush_i;
    assign result_o = result_q;
`endif

endmodule

// File: tb/tb_execute_muldiv.sv
// tb/tb_execute_muldiv.sv - scoreboard testbench for execute_muldiv
module tb_execute_muldiv;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    execute_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (start),
        .funct3_i (funct3),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .flush_i  (flush),
        .busy_o   (busy),
        .valid_o  (valid),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain RV32M arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
        if (f < 3'd4) return 0;
`endif
        if (f >= 3'd4 && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op; start stays high through DONE like a stalled pipeline.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int busy_n;
        bit seen;
        @(posedge clk); #1;
        start  = 1'b1;
        flush  = 1'b0;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        exp_q.push_back(model(f, a, b));
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
            else if (busy) busy_n++;
        end
        check($sformatf("seen_valid f3=%0d", f), 32'(seen), 32'd1);
        check($sformatf("busy_cycles f3=%0d a=%08h b=%08h", f, a, b), 32'(busy_n), 32'(exp_busy(f, a, b)));
    endtask

    task automatic idle();
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    // Monitor: every valid result is compared against the oldest expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (valid) begin
                check("valid_with_busy", 32'(busy), 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got result 0x%08h with empty queue", result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic [31:0] corner[4];
        corner[0] = 32'h0;
        corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        do_op(3'd0, 32'd7, 32'd6);
        idle();
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
        idle();
        do_op(3'd5, 32'd5, 32'd0);
        do_op(3'd6, 32'd5, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        idle();

        // Flush at CALC cycle 10.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_valid", 32'(valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_busy", 32'(busy), 32'd0);
        check("post_flush_valid", 32'(valid), 32'd0);
        do_op(3'd5, 32'd9, 32'd3);
        idle();

        // Start and flush together: no start.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
        @(negedge clk);
        check("start_flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start_flush_idle_busy", 32'(busy), 32'd0);
        check("start_flush_idle_valid", 32'(valid), 32'd0);

        // Randomized ops with corner operands mixed in.
        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(1, 20));
            do_op(rf, ra, rb);
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        // Reset in the middle of CALC.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd12345; rs2 = 32'd11;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_result", result, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        do_op(3'd7, 32'd100, 32'd7);
        idle();

        repeat (40) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
